// File: rtl/sync_pkg.sv
// Shared types and helpers for the multi-channel event synchroniser.
package sync_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int MIN_STAGES = 2;

  function automatic logic edge_hit(
    input edge_mode_t mode,
    input logic       cur,
    input logic       prv
  );
    logic hit;
    hit = 1'b0;
    unique case (mode)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = cur & ~prv;
      EDGE_FALL: hit = ~cur & prv;
      EDGE_BOTH: hit = cur ^ prv;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_channel.sv
// One channel: sync chain, optional stability filter (SYNC_GLITCH_FILTER_EN),
// edge detect, sticky flag and saturating counter.
module sync_channel
  import sync_pkg::*;
#(
  parameter int STAGES        = 2,
  parameter int CNT_W         = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             clr_sticky,
  input  logic             cnt_clr,
  output logic             level,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  if (STAGES < MIN_STAGES || FILTER_CYCLES < 1) begin : g_bad_cfg
    $error("sync_channel: STAGES or FILTER_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] chain;
  logic              raw;
  logic              prev;
  logic              hit;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], din};
  end

  assign raw = chain[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic [FW-1:0] fcnt;
  logic          flt;

  // Flip only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt <= '0;
      flt  <= 1'b0;
    end else if (raw == flt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
      fcnt <= '0;
      flt  <= raw;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign level = flt;
`else
  assign level = raw;
`endif

  assign hit = edge_hit(edge_mode_t'(mode), level, prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= 1'b0;
      pulse  <= 1'b0;
      sticky <= 1'b0;
      count  <= '0;
    end else begin
      prev   <= level;
      pulse  <= hit;
      // A same-cycle event beats the clear.
      sticky <= hit | (sticky & ~clr_sticky);
      if (hit) begin
        if (cnt_clr)               count <= CNT_W'(1);
        else if (count != CNT_MAX) count <= count + 1'b1;
      end else if (cnt_clr) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_event_sync.sv
// NUM_CH independent async-to-outclk event synchronisers.
// Optional glitch filter enabled by defining SYNC_GLITCH_FILTER_EN.
module multi_channel_event_sync
  import sync_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STAGES        = 2,
  parameter int CNT_W         = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                    outclk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       async_sig,
  input  logic [2*NUM_CH-1:0]     edge_mode,
  input  logic [NUM_CH-1:0]       clear_sticky,
  input  logic [NUM_CH-1:0]       count_clr,
  output logic [NUM_CH-1:0]       out_sync_sig,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       sticky,
  output logic [CNT_W*NUM_CH-1:0] event_count
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_channel #(
      .STAGES        (STAGES),
      .CNT_W         (CNT_W),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk        (outclk),
      .reset      (reset),
      .din        (async_sig[i]),
      .mode       (edge_mode[2*i +: 2]),
      .clr_sticky (clear_sticky[i]),
      .cnt_clr    (count_clr[i]),
      .level      (out_sync_sig[i]),
      .pulse      (pulse_out[i]),
      .sticky     (sticky[i]),
      .count      (event_count[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_channel_event_sync.sv
// Directed bench for multi_channel_event_sync (NUM_CH=4, STAGES=2, CNT_W=3).
module tb_multi_channel_event_sync;

  localparam int NUM_CH = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 3;
  localparam int FC     = 4;
`ifdef SYNC_GLITCH_FILTER_EN
  localparam int FL = FC;
`else
  localparam int FL = 0;
`endif
  localparam int PH = (FL == 0) ? 2 : FL + 2;

  logic                    outclk;
  logic                    reset;
  logic [NUM_CH-1:0]       async_sig;
  logic [2*NUM_CH-1:0]     edge_mode;
  logic [NUM_CH-1:0]       clear_sticky;
  logic [NUM_CH-1:0]       count_clr;
  logic [NUM_CH-1:0]       out_sync_sig;
  logic [NUM_CH-1:0]       pulse_out;
  logic [NUM_CH-1:0]       sticky;
  logic [CNT_W*NUM_CH-1:0] event_count;

  multi_channel_event_sync #(
    .NUM_CH        (NUM_CH),
    .STAGES        (STAGES),
    .CNT_W         (CNT_W),
    .FILTER_CYCLES (FC)
  ) dut (
    .outclk       (outclk),
    .reset        (reset),
    .async_sig    (async_sig),
    .edge_mode    (edge_mode),
    .clear_sticky (clear_sticky),
    .count_clr    (count_clr),
    .out_sync_sig (out_sync_sig),
    .pulse_out    (pulse_out),
    .sticky       (sticky),
    .event_count  (event_count)
  );

  initial outclk = 1'b0;
  always #5 outclk = ~outclk;

  typedef struct {
    int         ch;
    logic [1:0] mode;
    int         n;
    int         exp_cnt;
    int         exp_st;
  } vec_t;

  vec_t vecs[6];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge outclk);
  endtask

  function automatic int cnt(input int ch);
    return int'(event_count[CNT_W*ch +: CNT_W]);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulses(input int ch, input int n);
    repeat (n) begin
      async_sig[ch] = 1'b1;
      step(PH);
      async_sig[ch] = 1'b0;
      step(PH);
    end
    step(STAGES + FL + 2);
  endtask

  initial begin
    reset        = 1'b1;
    async_sig    = '0;
    edge_mode    = '0;
    clear_sticky = '0;
    count_clr    = '0;

    vecs[0] = '{1, 2'b00, 3, 0, 0};
    vecs[1] = '{1, 2'b01, 3, 3, 1};
    vecs[2] = '{1, 2'b10, 3, 3, 1};
    vecs[3] = '{1, 2'b11, 3, 6, 1};
    vecs[4] = '{2, 2'b01, 9, 7, 1};
    vecs[5] = '{3, 2'b11, 4, 7, 1};

    // Reset state and first-event latency on ch0.
    step(2);
    check("rst_sync",   int'(out_sync_sig), 0);
    check("rst_pulse",  int'(pulse_out), 0);
    check("rst_sticky", int'(sticky), 0);
    check("rst_count",  int'(event_count), 0);
    reset = 1'b0;
    edge_mode[1:0] = 2'b01;
    async_sig[0] = 1'b1;
    step(STAGES + FL - 1);
    check("lat_sync_early", int'(out_sync_sig[0]), 0);
    step(1);
    check("lat_sync",       int'(out_sync_sig[0]), 1);
    check("lat_pulse_early", int'(pulse_out[0]), 0);
    step(1);
    check("lat_pulse",  int'(pulse_out), 1);
    check("lat_sticky", int'(sticky), 1);
    check("lat_cnt0",   cnt(0), 1);
    check("lat_cnt_oth", int'(event_count) >> CNT_W, 0);
    step(1);
    check("lat_pulse_end", int'(pulse_out[0]), 0);
    async_sig = '0;
    step(PH + STAGES + FL);

    // Mode / saturation table.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      edge_mode = '0;
      edge_mode[2*vecs[v].ch +: 2] = vecs[v].mode;
      pulses(vecs[v].ch, vecs[v].n);
      for (int c = 0; c < NUM_CH; c++)
        check($sformatf("tbl%0d_cnt%0d", v, c), cnt(c),
              (c == vecs[v].ch) ? vecs[v].exp_cnt : 0);
      check($sformatf("tbl%0d_sticky", v),
            int'(sticky[vecs[v].ch]), vecs[v].exp_st);
    end

    // Counter clear colliding with an event, then a quiet clear.
    do_reset();
    edge_mode = '0;
    edge_mode[5:4] = 2'b01;
    pulses(2, 9);
    check("sat_hold", cnt(2), 7);
    async_sig[2] = 1'b1;
    step(STAGES + FL);
    count_clr[2] = 1'b1;
    step(1);
    count_clr[2] = 1'b0;
    check("clr_collide_cnt",   cnt(2), 1);
    check("clr_collide_pulse", int'(pulse_out[2]), 1);
    async_sig[2] = 1'b0;
    step(PH + STAGES + FL + 2);
    count_clr[2] = 1'b1;
    step(1);
    count_clr[2] = 1'b0;
    check("clr_quiet_cnt", cnt(2), 0);

    // Sticky clear colliding with an event, then a quiet clear.
    edge_mode[7:6] = 2'b01;
    async_sig[3] = 1'b1;
    step(STAGES + FL);
    clear_sticky[3] = 1'b1;
    step(1);
    clear_sticky[3] = 1'b0;
    check("sticky_collide", int'(sticky[3]), 1);
    step(3);
    clear_sticky[3] = 1'b1;
    step(1);
    clear_sticky[3] = 1'b0;
    check("sticky_quiet_clr", int'(sticky[3]), 0);
    async_sig[3] = 1'b0;

    // Reset mid-operation with an event in flight.
    do_reset();
    edge_mode = '0;
    edge_mode[1:0] = 2'b11;
    pulses(0, 2);
    check("mid_pre_cnt", cnt(0), 4);
    async_sig[0] = 1'b1;
    step(STAGES + FL);
    reset = 1'b1;
    step(1);
    check("mid_rst_pulse",  int'(pulse_out), 0);
    check("mid_rst_sticky", int'(sticky), 0);
    check("mid_rst_count",  int'(event_count), 0);
    check("mid_rst_sync",   int'(out_sync_sig), 0);
    step(1);
    edge_mode[1:0] = 2'b01;
    reset = 1'b0;
    begin
      int np;
      np = 0;
      repeat (STAGES + FL + 8) begin
        step(1);
        np += int'(pulse_out[0]);
      end
      check("held_high_pulses", np, 1);
      check("held_high_cnt", cnt(0), 1);
    end
    async_sig[0] = 1'b0;

`ifdef SYNC_GLITCH_FILTER_EN
    // Glitch rejection and filtered latency on ch1.
    do_reset();
    edge_mode = '0;
    edge_mode[3:2] = 2'b01;
    begin
      int seen_sync, seen_pulse, at;
      seen_sync = 0;
      seen_pulse = 0;
      async_sig[1] = 1'b1;
      step(3);
      async_sig[1] = 1'b0;
      repeat (12) begin
        step(1);
        seen_sync  |= int'(out_sync_sig[1]);
        seen_pulse |= int'(pulse_out[1]);
      end
      check("glitch_sync",  seen_sync, 0);
      check("glitch_pulse", seen_pulse, 0);
      at = -1;
      async_sig[1] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        step(1);
        if (i == 6) async_sig[1] = 1'b0;
        if (pulse_out[1] && at < 0) at = i;
      end
      check("filt_latency", at, STAGES + FC + 1);
      check("filt_cnt", cnt(1), 1);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
